// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the memory port arbiter.
package arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage : arb_pkg

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request scanning from ptr upward, mod NUM_REQ.
module rr_pick
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [SEL_W-1:0]   idx,
    output logic               valid
);

    logic [SEL_W-1:0] pos;

    // Scan from the farthest offset down so the nearest request to ptr is written last.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        pos   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pos = ptr + SEL_W'(k);
            if (req[pos]) begin
                idx   = pos;
                valid = 1'b1;
            end
        end
    end

endmodule : rr_pick

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port among 4 requesters, with bounded grant locking.
// Optional grant timeout abort enabled by defining ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no owner; arbitrate among pending requests from ptr
// GRANT | one requester owns the port; mem_req held until mem_ack (or timeout)
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_LOCK       = 4,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_WIDTH       = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] lock,
    input  logic               mem_ack,
    output logic [NUM_REQ-1:0] grant,
    output logic [SEL_W-1:0]   sel,
    output logic               mem_req,
    output logic [NUM_REQ-1:0] done,
    output logic               busy,
    output logic               timeout_err
);

    if (MAX_LOCK < 1 || MAX_LOCK > 15) begin : g_bad_max_lock
        $error("MAX_LOCK out of range 1..15");
    end
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > (2 ** TO_WIDTH)) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES out of range 2..2**TO_WIDTH");
    end

    arb_state_t       state;
    logic [SEL_W-1:0] ptr;
    logic [3:0]       lock_cnt;
    logic [SEL_W-1:0] pick_idx;
    logic             pick_valid;
    logic             stay;

    rr_pick u_pick (
        .req   (req),
        .ptr   (ptr),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign stay = lock[sel] & req[sel] & (lock_cnt < 4'(MAX_LOCK));

`ifdef ARB_TIMEOUT_EN
    localparam logic [TO_WIDTH-1:0] TO_LIMIT = TO_WIDTH'(TIMEOUT_CYCLES - 1);
    logic [TO_WIDTH-1:0] to_cnt;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= '0;
            sel         <= '0;
            mem_req     <= 1'b0;
            done        <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            ptr         <= '0;
            lock_cnt    <= '0;
`ifdef ARB_TIMEOUT_EN
            to_cnt      <= '0;
`endif
        end else begin
            done        <= '0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state    <= GRANT;
                        grant    <= NUM_REQ'(1) << pick_idx;
                        sel      <= pick_idx;
                        mem_req  <= 1'b1;
                        busy     <= 1'b1;
                        lock_cnt <= 4'd1;
`ifdef ARB_TIMEOUT_EN
                        to_cnt   <= '0;
`endif
                    end
                end
                GRANT: begin
                    if (mem_ack) begin
                        done <= grant;
                        if (stay) begin
                            lock_cnt <= lock_cnt + 4'd1;
`ifdef ARB_TIMEOUT_EN
                            to_cnt   <= '0;
`endif
                        end else begin
                            state    <= IDLE;
                            grant    <= '0;
                            mem_req  <= 1'b0;
                            busy     <= 1'b0;
                            ptr      <= sel + 1'b1;
                            lock_cnt <= '0;
                        end
`ifdef ARB_TIMEOUT_EN
                    end else if (to_cnt == TO_LIMIT) begin
                        // Abort: drop the owner without a done pulse and move priority past it.
                        state       <= IDLE;
                        grant       <= '0;
                        mem_req     <= 1'b0;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                        ptr         <= sel + 1'b1;
                        lock_cnt    <= '0;
                        to_cnt      <= '0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios then random traffic vs. a transaction-level model.
module tb_mem_port_arbiter;

    localparam int MAX_LOCK = 4;
    localparam int TIMEOUT  = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [3:0] lock;
    logic       mem_ack;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       mem_req;
    logic [3:0] done;
    logic       busy;
    logic       timeout_err;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .MAX_LOCK       (MAX_LOCK),
        .TIMEOUT_CYCLES (TIMEOUT),
        .TO_WIDTH       (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .lock        (lock),
        .mem_ack     (mem_ack),
        .grant       (grant),
        .sel         (sel),
        .mem_req     (mem_req),
        .done        (done),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    typedef struct {
        logic [3:0] grant;
        logic [1:0] sel;
        logic       mem_req;
        logic [3:0] done;
        logic       busy;
        logic       to;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   stim_done = 0;

    // Reference model: who owns the port, how many back-to-back transfers it has had,
    // how long the current transfer has been outstanding, and where the next scan starts.
    int owner    = -1;
    int streak   = 0;
    int age      = 0;
    int next_pos = 0;
    int last_sel = 0;

    function automatic exp_t model_step(logic [3:0] r, logic [3:0] l, logic a, logic rst);
        exp_t e;
        e.done = 4'b0;
        e.to   = 1'b0;
        if (rst) begin
            owner = -1; streak = 0; age = 0; next_pos = 0; last_sel = 0;
        end else if (owner < 0) begin
            for (int off = 0; off < 4; off++) begin
                int c;
                c = (next_pos + off) % 4;
                if (owner < 0 && r[c]) begin
                    owner = c; streak = 1; age = 1; last_sel = c;
                end
            end
        end else if (a) begin
            e.done[owner] = 1'b1;
            if (l[owner] && r[owner] && streak < MAX_LOCK) begin
                streak++; age = 1;
            end else begin
                next_pos = (owner + 1) % 4; owner = -1;
            end
        end else begin
`ifdef ARB_TIMEOUT_EN
            if (age == TIMEOUT) begin
                e.to = 1'b1; next_pos = (owner + 1) % 4; owner = -1;
            end else age++;
`else
            age++;
`endif
        end
        e.grant   = (owner >= 0) ? (4'b1 << owner) : 4'b0;
        e.sel     = 2'(last_sel);
        e.mem_req = (owner >= 0);
        e.busy    = (owner >= 0);
        return e;
    endfunction

    task automatic drive(input logic [3:0] r, input logic [3:0] l, input logic a, input logic rst);
        @(negedge clk);
        req = r; lock = l; mem_ack = a; reset = rst;
        exp_q.push_back(model_step(r, l, a, rst));
    endtask

    function automatic void check(input string name, input logic [3:0] act, input logic [3:0] want, input int cyc);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, want);
        end
    endfunction

    // Monitor: every edge that has a pending expectation is compared against the DUT.
    initial begin : monitor
        int cyc = 0;
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("grant",       grant,             e.grant,         cyc);
                check("sel",         {2'b0, sel},       {2'b0, e.sel},   cyc);
                check("mem_req",     {3'b0, mem_req},   {3'b0, e.mem_req}, cyc);
                check("done",        done,              e.done,          cyc);
                check("busy",        {3'b0, busy},      {3'b0, e.busy},  cyc);
                check("timeout_err", {3'b0, timeout_err}, {3'b0, e.to},  cyc);
            end
        end
    end

    initial begin : stimulus
        req = '0; lock = '0; mem_ack = 1'b0; reset = 1'b1;

        // Basic grant/release, next winner idx 2.
        drive(4'b0000, 4'b0000, 1'b0, 1'b1);
        drive(4'b0101, 4'b0000, 1'b0, 1'b0);
        drive(4'b0101, 4'b0000, 1'b0, 1'b0);
        drive(4'b0101, 4'b0000, 1'b0, 1'b0);
        drive(4'b0101, 4'b0000, 1'b1, 1'b0);
        drive(4'b0100, 4'b0000, 1'b0, 1'b0);
        drive(4'b0100, 4'b0000, 1'b1, 1'b0);
        drive(4'b0000, 4'b0000, 1'b0, 1'b0);

        // All requesting, acks always high: rotation with one IDLE cycle between grants.
        drive(4'b0000, 4'b0000, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) drive(4'b1111, 4'b0000, 1'b1, 1'b0);

        // Lock from ptr=2: reset, serve idx 1 once, then locked idx 2 runs to MAX_LOCK.
        drive(4'b0000, 4'b0000, 1'b0, 1'b1);
        drive(4'b0010, 4'b0000, 1'b0, 1'b0);
        drive(4'b0000, 4'b0000, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) drive(4'b0101, 4'b0100, 1'b1, 1'b0);

        // No ack for a long time on idx 1 (timeout when enabled, indefinite hold otherwise).
        drive(4'b0000, 4'b0000, 1'b0, 1'b1);
        drive(4'b0010, 4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) drive(4'b0110, 4'b0000, 1'b0, 1'b0);
        drive(4'b0110, 4'b0000, 1'b1, 1'b0);
        drive(4'b0000, 4'b0000, 1'b1, 1'b0);

        // Ack exactly in the limit cycle.
        drive(4'b0000, 4'b0000, 1'b0, 1'b1);
        drive(4'b0010, 4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < TIMEOUT - 1; i++) drive(4'b0010, 4'b0000, 1'b0, 1'b0);
        drive(4'b0010, 4'b0000, 1'b1, 1'b0);
        drive(4'b0000, 4'b0000, 1'b0, 1'b0);

        // Reset mid-grant with ack high, then idx 3 from a fresh pointer.
        drive(4'b0000, 4'b0000, 1'b0, 1'b1);
        drive(4'b0100, 4'b0000, 1'b0, 1'b0);
        drive(4'b0100, 4'b0000, 1'b1, 1'b1);
        drive(4'b1000, 4'b0000, 1'b0, 1'b0);
        drive(4'b1000, 4'b0000, 1'b1, 1'b0);
        drive(4'b0000, 4'b0000, 1'b0, 1'b0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 299) == 0));
        end

        drive(4'b0000, 4'b0000, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
        end
        stim_done = 1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_mem_port_arbiter
